// File: rtl/updown_counter_fnd.sv
// rtl/updown_counter_fnd.sv - prescaled up/down counter with multiplexed hex seven-segment display
module updown_counter_fnd #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 1000,
    parameter int SATURATE = 0
) (
    input  logic                   clk_1k,
    input  logic                   reset,
    input  logic [1:0]             mode_in,
    input  logic                   load,
    input  logic [WIDTH-1:0]       data_in,
    output logic [1:0]             mode_out,
    output logic [WIDTH-1:0]       count,
    output logic                   tc,
    output logic [WIDTH/4-1:0]     seg_com,
    output logic [7:0]             seg_data
);
    localparam int DIGITS = WIDTH / 4;
    localparam int PW     = $clog2(TICK_DIV);
    localparam int SW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]    SCAN_LAST  = SW'(DIGITS - 1);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [DIGITS-1:0] COM_ONE   = DIGITS'(1);

    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [PW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [1:0]        mode_q, mode_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              tc_q, tc_d;
    logic [DIGITS-1:0] seg_com_q, seg_com_d;
    logic [7:0]        seg_data_q, seg_data_d;

    logic              tick;
    logic              at_top;
    logic              at_bot;
    logic [3:0]        nibble;

    function automatic logic [7:0] hex_glyph(input logic [3:0] h);
        case (h)
            4'h0: hex_glyph = 8'hFC;
            4'h1: hex_glyph = 8'h60;
            4'h2: hex_glyph = 8'hDA;
            4'h3: hex_glyph = 8'hF2;
            4'h4: hex_glyph = 8'h66;
            4'h5: hex_glyph = 8'hB6;
            4'h6: hex_glyph = 8'hBE;
            4'h7: hex_glyph = 8'hE0;
            4'h8: hex_glyph = 8'hFE;
            4'h9: hex_glyph = 8'hF6;
            4'hA: hex_glyph = 8'hEE;
            4'hB: hex_glyph = 8'h3E;
            4'hC: hex_glyph = 8'h9C;
            4'hD: hex_glyph = 8'h7A;
            4'hE: hex_glyph = 8'h9E;
            default: hex_glyph = 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clk_1k) begin
        if (reset) begin
            presc_q    <= '0;
            scan_q     <= '0;
            mode_q     <= MODE_UP;
            count_q    <= '0;
            tc_q       <= 1'b0;
            seg_com_q  <= '1;
            seg_data_q <= 8'h00;
        end else begin
            presc_q    <= presc_d;
            scan_q     <= scan_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            tc_q       <= tc_d;
            seg_com_q  <= seg_com_d;
            seg_data_q <= seg_data_d;
        end
    end

    assign tick   = (presc_q == PRESC_LAST);
    assign at_top = (count_q == CNT_MAX);
    assign at_bot = (count_q == '0);

    always_comb begin
        case (mode_in)
            MODE_UP:   mode_d = MODE_UP;
            MODE_DN:   mode_d = MODE_DN;
            MODE_HOLD: mode_d = MODE_HOLD;
            default:   mode_d = mode_q;
        endcase
    end

    // Counting follows mode_q, the direction held before this edge.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = data_in;
            presc_d = '0;
        end else if (tick) begin
            if (mode_q == MODE_UP) begin
                tc_d = at_top;
                if (!(at_top && SATURATE != 0))
                    count_d = count_q + CNT_ONE;
            end else if (mode_q == MODE_DN) begin
                tc_d = at_bot;
                if (!(at_bot && SATURATE != 0))
                    count_d = count_q - CNT_ONE;
            end
        end
    end

    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_q == SW'(i))
                nibble = count_q[4*i +: 4];
        end
        scan_d     = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
        seg_com_d  = ~(COM_ONE << scan_q);
        seg_data_d = hex_glyph(nibble);
    end

    assign mode_out = mode_q;
    assign count    = count_q;
    assign tc       = tc_q;
    assign seg_com  = seg_com_q;
    assign seg_data = seg_data_q;
endmodule

// File: tb/tb_updown_counter_fnd.sv
// tb/tb_updown_counter_fnd.sv - directed bench for updown_counter_fnd, wrap and clamp instances
module tb_updown_counter_fnd;
    logic       clk_1k = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode_in = 2'b00;
    logic       load = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [1:0] mode_out_w, mode_out_s;
    logic [7:0] count_w, count_s;
    logic       tc_w, tc_s;
    logic [1:0] seg_com_w, seg_com_s;
    logic [7:0] seg_data_w, seg_data_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_1k = ~clk_1k;

    updown_counter_fnd #(.WIDTH(8), .TICK_DIV(4), .SATURATE(0)) dut_w (
        .clk_1k(clk_1k), .reset(reset), .mode_in(mode_in), .load(load), .data_in(data_in),
        .mode_out(mode_out_w), .count(count_w), .tc(tc_w), .seg_com(seg_com_w), .seg_data(seg_data_w)
    );

    updown_counter_fnd #(.WIDTH(8), .TICK_DIV(4), .SATURATE(1)) dut_s (
        .clk_1k(clk_1k), .reset(reset), .mode_in(mode_in), .load(load), .data_in(data_in),
        .mode_out(mode_out_s), .count(count_s), .tc(tc_s), .seg_com(seg_com_s), .seg_data(seg_data_s)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_1k);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; mode_in = 2'b00; data_in = 8'h00;
        step(2);
        vectors++; if (count_w !== 8'h00) begin miscompares++; $display("FAIL reset_count: got %h expected 00", count_w); end
        vectors++; if (mode_out_w !== 2'b10) begin miscompares++; $display("FAIL reset_mode: got %b expected 10", mode_out_w); end
        vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL reset_tc: got %b expected 0", tc_w); end
        vectors++; if (seg_com_w !== 2'b11) begin miscompares++; $display("FAIL reset_seg_com: got %b expected 11", seg_com_w); end
        vectors++; if (seg_data_w !== 8'h00) begin miscompares++; $display("FAIL reset_seg_data: got %h expected 00", seg_data_w); end
    endtask

    task automatic test_count();
        logic [7:0] exp;
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            exp = 8'(k / 4);
            vectors++; if (count_w !== exp) begin miscompares++; $display("FAIL count_step%0d: got %h expected %h", k, count_w, exp); end
            vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL count_tc%0d: got %b expected 0", k, tc_w); end
            vectors++; if (mode_out_w !== 2'b10) begin miscompares++; $display("FAIL count_mode%0d: got %b expected 10", k, mode_out_w); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_w, exp_s;
        load = 1'b1; data_in = 8'hFE; mode_in = 2'b10;
        step(1);
        load = 1'b0; mode_in = 2'b00;
        vectors++; if (count_w !== 8'hFE) begin miscompares++; $display("FAIL wrap_load: got %h expected FE", count_w); end
        vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL wrap_load_tc: got %b expected 0", tc_w); end
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_w = (k < 4) ? 8'hFE : (k < 8) ? 8'hFF : 8'h00;
            exp_s = (k < 4) ? 8'hFE : 8'hFF;
            vectors++; if (count_w !== exp_w) begin miscompares++; $display("FAIL wrap_count%0d: got %h expected %h", k, count_w, exp_w); end
            vectors++; if (count_s !== exp_s) begin miscompares++; $display("FAIL clamp_up_count%0d: got %h expected %h", k, count_s, exp_s); end
            vectors++; if (tc_w !== (k == 8)) begin miscompares++; $display("FAIL wrap_tc%0d: got %b expected %b", k, tc_w, (k == 8)); end
            vectors++; if (tc_s !== (k == 8)) begin miscompares++; $display("FAIL clamp_up_tc%0d: got %b expected %b", k, tc_s, (k == 8)); end
        end
        step(1);
        vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL wrap_tc_drop: got %b expected 0", tc_w); end
        vectors++; if (count_w !== 8'h00) begin miscompares++; $display("FAIL wrap_after: got %h expected 00", count_w); end
    endtask

    task automatic test_clamp();
        logic [7:0] exp_w;
        load = 1'b1; data_in = 8'h00; mode_in = 2'b01;
        step(1);
        load = 1'b0; mode_in = 2'b00;
        vectors++; if (mode_out_s !== 2'b01) begin miscompares++; $display("FAIL clamp_mode: got %b expected 01", mode_out_s); end
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_w = (k < 4) ? 8'h00 : (k < 8) ? 8'hFF : 8'hFE;
            vectors++; if (count_s !== 8'h00) begin miscompares++; $display("FAIL clamp_count%0d: got %h expected 00", k, count_s); end
            vectors++; if (tc_s !== (k == 4 || k == 8)) begin miscompares++; $display("FAIL clamp_tc%0d: got %b expected %b", k, tc_s, (k == 4 || k == 8)); end
            vectors++; if (count_w !== exp_w) begin miscompares++; $display("FAIL down_wrap_count%0d: got %h expected %h", k, count_w, exp_w); end
            vectors++; if (tc_w !== (k == 4)) begin miscompares++; $display("FAIL down_wrap_tc%0d: got %b expected %b", k, tc_w, (k == 4)); end
        end
        vectors++; if (mode_out_s !== 2'b01) begin miscompares++; $display("FAIL clamp_mode_kept: got %b expected 01", mode_out_s); end
    endtask

    task automatic test_hold();
        load = 1'b1; data_in = 8'h37; mode_in = 2'b10;
        step(1);
        load = 1'b0; mode_in = 2'b11;
        step(1);
        mode_in = 2'b00;
        vectors++; if (mode_out_w !== 2'b11) begin miscompares++; $display("FAIL hold_mode: got %b expected 11", mode_out_w); end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            vectors++; if (count_w !== 8'h37) begin miscompares++; $display("FAIL hold_count%0d: got %h expected 37", k, count_w); end
            vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL hold_tc%0d: got %b expected 0", k, tc_w); end
        end
        mode_in = 2'b10;
        step(1);
        mode_in = 2'b00;
        step(2);
        vectors++; if (count_w !== 8'h37) begin miscompares++; $display("FAIL resume_early: got %h expected 37", count_w); end
        step(1);
        vectors++; if (count_w !== 8'h38) begin miscompares++; $display("FAIL resume_count: got %h expected 38", count_w); end
        step(3);
        mode_in = 2'b11;
        step(1);
        mode_in = 2'b00;
        vectors++; if (count_w !== 8'h39) begin miscompares++; $display("FAIL mode_on_tick_count: got %h expected 39", count_w); end
        vectors++; if (mode_out_w !== 2'b11) begin miscompares++; $display("FAIL mode_on_tick_mode: got %b expected 11", mode_out_w); end
        step(4);
        vectors++; if (count_w !== 8'h39) begin miscompares++; $display("FAIL mode_on_tick_held: got %h expected 39", count_w); end
        vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL mode_on_tick_tc: got %b expected 0", tc_w); end
    endtask

    task automatic test_load_on_tick();
        load = 1'b1; data_in = 8'h10; mode_in = 2'b10;
        step(1);
        load = 1'b0; mode_in = 2'b00;
        step(3);
        load = 1'b1; data_in = 8'hFF;
        step(1);
        load = 1'b0;
        vectors++; if (count_w !== 8'hFF) begin miscompares++; $display("FAIL load_tick_count: got %h expected FF", count_w); end
        vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL load_tick_tc: got %b expected 0", tc_w); end
        step(3);
        vectors++; if (count_w !== 8'hFF) begin miscompares++; $display("FAIL load_presc_restart: got %h expected FF", count_w); end
        step(1);
        vectors++; if (count_w !== 8'h00) begin miscompares++; $display("FAIL load_next_tick: got %h expected 00", count_w); end
        vectors++; if (tc_w !== 1'b1) begin miscompares++; $display("FAIL load_next_tc: got %b expected 1", tc_w); end
        vectors++; if (count_s !== 8'hFF) begin miscompares++; $display("FAIL load_next_clamp: got %h expected FF", count_s); end
    endtask

    task automatic test_scan();
        reset = 1'b1;
        step(1);
        reset = 1'b0; load = 1'b1; data_in = 8'h3A;
        step(1);
        load = 1'b0;
        vectors++; if (seg_com_w !== 2'b10) begin miscompares++; $display("FAIL scan0_com: got %b expected 10", seg_com_w); end
        vectors++; if (seg_data_w !== 8'hFC) begin miscompares++; $display("FAIL scan0_data: got %h expected FC", seg_data_w); end
        for (int k = 1; k <= 4; k++) begin
            step(1);
            if (k % 2 == 1) begin
                vectors++; if (seg_com_w !== 2'b01) begin miscompares++; $display("FAIL scan%0d_com: got %b expected 01", k, seg_com_w); end
                vectors++; if (seg_data_w !== 8'hF2) begin miscompares++; $display("FAIL scan%0d_data: got %h expected F2", k, seg_data_w); end
            end else begin
                vectors++; if (seg_com_w !== 2'b10) begin miscompares++; $display("FAIL scan%0d_com: got %b expected 10", k, seg_com_w); end
                vectors++; if (seg_data_w !== 8'hEE) begin miscompares++; $display("FAIL scan%0d_data: got %h expected EE", k, seg_data_w); end
            end
        end
    endtask

    task automatic test_reset_override();
        load = 1'b1; data_in = 8'h00; mode_in = 2'b01;
        step(1);
        load = 1'b0; mode_in = 2'b00;
        step(3);
        reset = 1'b1; load = 1'b1; data_in = 8'h55;
        step(1);
        vectors++; if (count_w !== 8'h00) begin miscompares++; $display("FAIL ovr_count: got %h expected 00", count_w); end
        vectors++; if (seg_com_w !== 2'b11) begin miscompares++; $display("FAIL ovr_seg_com: got %b expected 11", seg_com_w); end
        vectors++; if (seg_data_w !== 8'h00) begin miscompares++; $display("FAIL ovr_seg_data: got %h expected 00", seg_data_w); end
        vectors++; if (mode_out_w !== 2'b10) begin miscompares++; $display("FAIL ovr_mode: got %b expected 10", mode_out_w); end
        vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL ovr_tc: got %b expected 0", tc_w); end
        reset = 1'b0; load = 1'b0;
        step(3);
        vectors++; if (count_w !== 8'h00) begin miscompares++; $display("FAIL first_tick_early: got %h expected 00", count_w); end
        step(1);
        vectors++; if (count_w !== 8'h01) begin miscompares++; $display("FAIL first_tick: got %h expected 01", count_w); end
        vectors++; if (tc_w !== 1'b0) begin miscompares++; $display("FAIL first_tick_tc: got %b expected 0", tc_w); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_clamp();
        test_hold();
        test_load_on_tick();
        test_scan();
        test_reset_override();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/updown_counter_fnd.md
UPDOWN_COUNTER_FND -- requirements
Module: updown_counter_fnd

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; SHALL be a multiple of 4 in range 4..16.
REQ-002 Parameter TICK_DIV, default 1000, clk_1k cycles per count tick; SHALL be >= 2.
REQ-003 Parameter SATURATE, default 0, end-of-range behaviour: 0 = wrap, 1 = clamp.
REQ-004 Derived constant DIGITS = WIDTH/4, the number of hex display digits.
REQ-005 clk_1k  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mode_in  input  2  direction request: 2'b10 up, 2'b01 down, 2'b11 hold, 2'b00 no change.
REQ-008 load  input  1  synchronous load request.
REQ-009 data_in  input  WIDTH  load value.
REQ-010 mode_out  output  2  registered current mode: 2'b10 up, 2'b01 down, 2'b11 hold.
REQ-011 count  output  WIDTH  registered counter value.
REQ-012 tc  output  1  registered terminal-count pulse.
REQ-013 seg_com  output  DIGITS  digit enables, active-low, one-hot.
REQ-014 seg_data  output  8  segments {a,b,c,d,e,f,g,dp}, active-high; dp always 0.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; internal tick SHALL be 1 in the cycle where the prescaler equals TICK_DIV-1.
REQ-016 Mode register SHALL update on every edge from mode_in as follows: 10 -> up, 01 -> down, 11 -> hold, 00 -> unchanged.
REQ-017 Counting SHALL use the mode value held before the edge; a mode_in change coincident with a tick affects only later ticks.
REQ-018 Priority SHALL be reset > load > tick.
REQ-019 When load=1, count SHALL take data_in at that edge and the prescaler SHALL restart at 0, whether or not a tick is due; tc SHALL be 0 on that edge.
REQ-020 On a tick without load, count SHALL change as follows: up -> +1; down -> -1; hold -> unchanged.
REQ-021 Wrap mode (SATURATE=0): up from 2^WIDTH-1 SHALL give 0; down from 0 SHALL give 2^WIDTH-1.
REQ-022 Clamp mode (SATURATE=1): up at 2^WIDTH-1 and down at 0 SHALL leave count unchanged.
REQ-023 tc SHALL be 1 for exactly the cycle after a tick edge at which count was at the terminal value for the active direction (max for up, 0 for down), in either SATURATE mode. tc SHALL never assert in hold.
REQ-024 Scan index SHALL advance 0..DIGITS-1 by one every clk_1k edge and wrap to 0.
REQ-025 At each non-reset edge, seg_com SHALL drive low only the bit equal to the current scan index.
REQ-026 At the same edge, seg_data SHALL be the hex glyph of count nibble [4i+3:4i], where i is the current scan index, using count as held before the edge; display latency is 1 cycle.
REQ-027 Hex glyphs SHALL be, for digits 0-F: FC,60,DA,F2,66,B6,BE,E0,FE,F6,EE,3E,9C,7A,9E,8E.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set count=0, prescaler=0, scan index=0, mode=up (mode_out=2'b10), tc=0, seg_com=all ones (blank), seg_data=8'h00.
REQ-029 Reset SHALL override load and tick in the same cycle, including mid-count and mid-scan.
REQ-030 The first tick after reset release SHALL occur TICK_DIV edges later.

Verification (WIDTH=8, TICK_DIV=4 unless stated)
REQ-031 Scenario: release reset, mode_in=00, run 12 cycles -> count steps 1,2,3 every 4 cycles; mode_out=10; tc=0.
REQ-032 Scenario: load with data_in=8'hFE, then mode up, SATURATE=0 -> count FE, FF, 00; tc=1 for one cycle after the FF->00 edge.
REQ-033 Scenario: SATURATE=1, load 8'h00, then mode_in=01 for one cycle -> mode_out=01; count stays 00 on every tick; tc pulses once per tick.
REQ-034 Scenario: mode_in=11 mid-count at 8'h37 -> count held at 37; tc=0; mode_out=11; mode_in=10 resumes counting at 38.
REQ-035 Scenario: count=8'h3A, observe scan -> seg_com alternates 2'b10 (digit 0, seg_data=EE) and 2'b01 (digit 1, seg_data=F2).
REQ-036 Scenario: assert reset concurrent with load=1 and a tick -> count=00, seg_com=2'b11, mode_out=10, tc=0 the next cycle.
